change_dispenser: RTL and testbench
===================================

// Module: change_dispenser
// PURPOSE
//  Pays change out of the vending machine as a sequence of coin ejections.
//  Uses the same 2-bit coin code as the coin-input bus: 01 = nickel (5), 10 = dime (10).
//  Takes an owed amount in nickel units and drives the hopper with a valid/ready handshake,
//  greedy dimes first. Sits between the vend controller (start/amount) and the coin hopper.
// PARAMETERS
//  AMT_W       4  width of amount/remain/paid, in nickel units (max 2^AMT_W-1)
//  GAP_CYCLES  2  idle cycles forced between consecutive coins (0 allowed)
// PORTS
//  clk         in   1      clock
//  rst         in   1      reset, synchronous, active-high
//  start       in   1      request payout; sampled only in IDLE
//  amount      in   AMT_W  nickels owed; latched when start is accepted
//  coin        out  2      coin offered: 00 none, 01 nickel, 10 dime
//  coin_valid  out  1      coin is offered to the hopper
//  coin_ready  in   1      hopper accepts the offered coin on this edge
//  dime_empty  in   1      dime tube empty
//  nick_empty  in   1      nickel tube empty
//  busy        out  1      payout in progress
//  done        out  1      one-cycle pulse: payout complete
//  fault       out  1      payout aborted: cannot make change
//  paid        out  AMT_W  nickels paid in the current or last payout
// BEHAVIOUR
//  Reset values
//  - All outputs are registered.
//  - On reset: state=IDLE; coin=00, coin_valid=0, busy=0, done=0, fault=0, paid=0; remain=0.
//  States: IDLE, SELECT, OFFER, GAP, DONE, FAULT.
//  IDLE
//  - start=1 at edge N: remain<=amount, paid<=0, fault<=0, busy<=1; go to SELECT.
//  - start is ignored in every other state.
//  SELECT (one cycle; dime_empty and nick_empty are sampled here only)
//  - remain==0                  -> DONE
//  - remain>=2 && !dime_empty   -> OFFER, coin<=10
//  - remain>=1 && !nick_empty   -> OFFER, coin<=01
//  - otherwise                  -> FAULT
//  - coin_valid<=1 on entry to OFFER, so the first coin is valid after edge N+1.
//  OFFER
//  - coin and coin_valid are held stable until coin_ready=1 is sampled on an edge.
//  - On the accepting edge: remain -= value, paid += value, coin_valid<=0, coin<=00.
//    Then go to GAP, or to SELECT if GAP_CYCLES==0.
//  - Empty flags changing during OFFER never withdraw or alter the offered coin.
//  GAP
//  - Exactly GAP_CYCLES cycles with coin_valid=0, then SELECT.
//  DONE
//  - done=1 for exactly one cycle and busy<=0 on the same edge; next state IDLE.
//  FAULT
//  - One cycle, then IDLE; busy<=0.
//  - fault is set and stays sticky until the next accepted start or rst.
//  - remain is not cleared, so paid shows the partial payout.
//  Arithmetic
//  - A dime is subtracted only when remain>=2, so remain never underflows.
//  - paid never exceeds the latched amount.
//  Reset mid-operation
//  - rst on any edge returns all outputs to reset values on that edge.
//  - A coin offered but not accepted is not counted in paid.
// TESTING
//  1. amount=3, coin_ready=1, both tubes full
//     -> coins 10 then 01, GAP_CYCLES idle cycles between; paid=3; one done pulse; fault=0.
//  2. amount=4, dime_empty=1
//     -> four 01 handshakes, paid=4, done pulse; coin never equals 10.
//  3. amount=0
//     -> done high in the cycle after edge N+1; coin_valid never asserted; paid=0.
//  4. amount=1, nick_empty=1
//     -> fault=1, no coin_valid, busy=0.
//     Then start with nick_empty=0 -> fault clears, one 01 coin paid.
//  5. amount=2, coin_ready low for 10 cycles while dime_empty toggles
//     -> coin=10 and coin_valid stable throughout; accepted on the first ready edge.
//  6. rst while coin_valid=1 -> all outputs reset next cycle.
//     start pulsed while busy -> ignored, amount not re-latched.

Source files
------------

// File: rtl/change_dispenser.sv
// change_dispenser: pays owed change (in nickel units) to the coin hopper as a
// series of valid/ready coin offers, dimes first while at least two nickels
// remain owed and dimes are available, otherwise nickels. A payout that cannot
// be completed from the tubes is aborted with a sticky fault, leaving paid at
// the partial amount.
module change_dispenser #(
  parameter int AMT_W      = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  output logic [1:0]       coin,
  output logic             coin_valid,
  input  logic             coin_ready,
  input  logic             dime_empty,
  input  logic             nick_empty,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [AMT_W-1:0] paid
);

  // Controller states
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SELECT = 3'd1;
  localparam logic [2:0] S_OFFER  = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_FAULT  = 3'd5;

  // Coin codes shared with the coin-input bus
  localparam logic [1:0] COIN_NONE   = 2'b00;
  localparam logic [1:0] COIN_NICKEL = 2'b01;
  localparam logic [1:0] COIN_DIME   = 2'b10;

  // Gap counter must hold GAP_CYCLES; keep at least one bit when no gap is used
  localparam int GAP_W = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

  // Value of a coin code in nickel units
  function automatic logic [AMT_W-1:0] coin_value(input logic [1:0] c);
    logic [AMT_W-1:0] v;
    case (c)
      COIN_DIME:   v = AMT_W'(2);
      COIN_NICKEL: v = AMT_W'(1);
      default:     v = '0;
    endcase
    return v;
  endfunction

  // Greedy coin choice for a non-zero remainder; COIN_NONE means no coin fits.
  // The compare is done one bit wider so the constant 2 survives narrow AMT_W.
  function automatic logic [1:0] pick_coin(input logic [AMT_W-1:0] rem,
                                           input logic             d_empty,
                                           input logic             n_empty);
    logic [1:0] c;
    c = COIN_NONE;
    if (({1'b0, rem} >= (AMT_W + 1)'(2)) && !d_empty) begin
      c = COIN_DIME;
    end else if ((rem != '0) && !n_empty) begin
      c = COIN_NICKEL;
    end
    return c;
  endfunction

  logic [2:0]       state_q,  state_d;
  logic [AMT_W-1:0] remain_q, remain_d;
  logic [AMT_W-1:0] paid_q,   paid_d;
  logic [1:0]       coin_q,   coin_d;
  logic             valid_q,  valid_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic             fault_q,  fault_d;
  logic [GAP_W-1:0] gap_q,    gap_d;
  logic [1:0]       sel_coin;

  assign sel_coin = pick_coin(remain_q, dime_empty, nick_empty);

  // Next-state and next-output computation for the payout sequencer
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    paid_d   = paid_q;
    coin_d   = coin_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    fault_d  = fault_q;
    gap_d    = gap_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          remain_d = amount;
          paid_d   = '0;
          fault_d  = 1'b0;
          busy_d   = 1'b1;
          state_d  = S_SELECT;
        end
      end

      // Tube flags only matter here; a coin once offered is never changed
      S_SELECT: begin
        if (remain_q == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else if (sel_coin != COIN_NONE) begin
          coin_d  = sel_coin;
          valid_d = 1'b1;
          state_d = S_OFFER;
        end else begin
          fault_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_FAULT;
        end
      end

      // Hold the offer until the hopper takes it; count it only when taken
      S_OFFER: begin
        if (coin_ready) begin
          remain_d = remain_q - coin_value(coin_q);
          paid_d   = paid_q + coin_value(coin_q);
          valid_d  = 1'b0;
          coin_d   = COIN_NONE;
          if (GAP_CYCLES == 0) begin
            state_d = S_SELECT;
          end else begin
            gap_d   = GAP_LOAD;
            state_d = S_GAP;
          end
        end
      end

      S_GAP: begin
        if (gap_q <= GAP_W'(1)) begin
          gap_d   = '0;
          state_d = S_SELECT;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end

      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset returns every output to idle values
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      remain_q <= '0;
      paid_q   <= '0;
      coin_q   <= COIN_NONE;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      paid_q   <= paid_d;
      coin_q   <= coin_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      fault_q  <= fault_d;
      gap_q    <= gap_d;
    end
  end

  assign coin       = coin_q;
  assign coin_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fault      = fault_q;
  assign paid       = paid_q;

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: cycle-by-cycle comparison of change_dispenser against a
// behavioural payout model, with directed scenarios pinned by literal values
// and a long randomized run.
module tb_change_dispenser;

  localparam int GAP = 2;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] amount;
  logic [1:0] coin;
  logic       coin_valid;
  logic       coin_ready;
  logic       dime_empty;
  logic       nick_empty;
  logic       busy;
  logic       done;
  logic       fault;
  logic [3:0] paid;

  change_dispenser #(.AMT_W(4), .GAP_CYCLES(GAP)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .amount     (amount),
    .coin       (coin),
    .coin_valid (coin_valid),
    .coin_ready (coin_ready),
    .dime_empty (dime_empty),
    .nick_empty (nick_empty),
    .busy       (busy),
    .done       (done),
    .fault      (fault),
    .paid       (paid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Behavioural model: phase 0 idle, 1 choosing, 2 coin on offer,
  // 3 spacing after a coin, 4 completion pulse, 5 abort
  int   ph;
  int   m_remain, m_paid, m_amt, m_gap;
  logic [1:0] m_coin;
  logic m_valid, m_busy, m_done, m_fault;

  // Observed-event counters for the directed scenarios
  int n_dacc, n_nacc, n_done, n_vcyc, n_dime_seen, first_acc;

  task automatic clr_counts();
    n_dacc = 0; n_nacc = 0; n_done = 0; n_vcyc = 0; n_dime_seen = 0; first_acc = 0;
  endtask

  task automatic model_step(input logic r, input logic s, input logic [3:0] a,
                            input logic rdy, input logic de, input logic ne);
    int v;
    if (r) begin
      ph = 0; m_remain = 0; m_paid = 0; m_amt = 0; m_gap = 0;
      m_coin = 2'b00; m_valid = 0; m_busy = 0; m_done = 0; m_fault = 0;
    end else begin
      m_done = 0;
      case (ph)
        0: if (s) begin
             m_amt = a; m_remain = a; m_paid = 0; m_fault = 0; m_busy = 1; ph = 1;
           end
        1: if (m_remain == 0) begin
             m_done = 1; m_busy = 0; ph = 4;
           end else if (m_remain >= 2 && !de) begin
             m_coin = 2'b10; m_valid = 1; ph = 2;
           end else if (!ne) begin
             m_coin = 2'b01; m_valid = 1; ph = 2;
           end else begin
             m_fault = 1; m_busy = 0; ph = 5;
           end
        2: if (rdy) begin
             v = (m_coin == 2'b10) ? 2 : 1;
             m_remain -= v; m_paid += v;
             m_coin = 2'b00; m_valid = 0;
             if (GAP == 0) ph = 1;
             else begin m_gap = GAP; ph = 3; end
           end
        3: begin
             m_gap--;
             if (m_gap == 0) ph = 1;
           end
        default: ph = 0;
      endcase
    end
  endtask

  task automatic compare();
    n_vec++;
    if (coin !== m_coin || coin_valid !== m_valid || busy !== m_busy ||
        done !== m_done || fault !== m_fault || paid !== m_paid[3:0]) begin
      n_err++;
      $display("FAIL cycle %0d outputs: got coin=%0d v=%0d busy=%0d done=%0d fault=%0d paid=%0d, want coin=%0d v=%0d busy=%0d done=%0d fault=%0d paid=%0d",
               cyc, coin, coin_valid, busy, done, fault, paid,
               m_coin, m_valid, m_busy, m_done, m_fault, m_paid);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Apply one input vector across one rising edge, then compare at the falling edge
  task automatic tick(input logic r, input logic s, input logic [3:0] a,
                      input logic rdy, input logic de, input logic ne);
    if (!r && coin_valid === 1'b1 && rdy) begin
      if (n_dacc + n_nacc == 0) first_acc = coin;
      if (coin == 2'b10) n_dacc++;
      else if (coin == 2'b01) n_nacc++;
    end
    rst = r; start = s; amount = a; coin_ready = rdy; dime_empty = de; nick_empty = ne;
    model_step(r, s, a, rdy, de, ne);
    @(negedge clk);
    cyc++;
    compare();
    if (done === 1'b1) n_done++;
    if (coin_valid === 1'b1) begin
      n_vcyc++;
      if (coin == 2'b10) n_dime_seen++;
    end
  endtask

  // Run with start low until the model is idle again, within a cycle budget
  task automatic wait_payout(input int budget, input int rdy_pct,
                             input logic de, input logic ne);
    int k;
    k = 0;
    while (ph != 0 && k < budget) begin
      tick(1'b0, 1'b0, 4'd0, ($urandom_range(0, 99) < rdy_pct), de, ne);
      k++;
    end
    if (ph != 0) begin
      n_vec++; n_err++;
      $display("FAIL payout timeout: still busy after %0d cycles, want idle", budget);
    end
  endtask

  initial begin
    // Reset
    clr_counts();
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    chk("reset coin", coin, 0);
    chk("reset coin_valid", coin_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset done/fault/paid", {done, fault, paid}, 0);
    tick(0, 0, 0, 0, 0, 0);

    // 1: amount 3, tubes full, hopper always ready
    clr_counts();
    tick(0, 1, 4'd3, 1, 0, 0);
    chk("t1 busy after start", busy, 1);
    wait_payout(100, 100, 0, 0);
    chk("t1 paid", paid, 3);
    chk("t1 dimes", n_dacc, 1);
    chk("t1 nickels", n_nacc, 1);
    chk("t1 first coin dime", first_acc, 2);
    chk("t1 done pulses", n_done, 1);
    chk("t1 fault", fault, 0);

    // 2: amount 4, no dimes
    clr_counts();
    tick(0, 1, 4'd4, 1, 1, 0);
    wait_payout(100, 100, 1, 0);
    chk("t2 paid", paid, 4);
    chk("t2 nickels", n_nacc, 4);
    chk("t2 dime offered", n_dime_seen, 0);
    chk("t2 done pulses", n_done, 1);

    // 3: amount 0
    clr_counts();
    tick(0, 1, 4'd0, 1, 0, 0);
    tick(0, 0, 4'd0, 1, 0, 0);
    chk("t3 done after N+1", done, 1);
    chk("t3 busy", busy, 0);
    wait_payout(20, 100, 0, 0);
    chk("t3 coin_valid cycles", n_vcyc, 0);
    chk("t3 paid", paid, 0);

    // 4: amount 1 with empty nickel tube, then retry
    clr_counts();
    tick(0, 1, 4'd1, 1, 0, 1);
    wait_payout(20, 100, 0, 1);
    chk("t4 fault", fault, 1);
    chk("t4 busy", busy, 0);
    chk("t4 coin_valid cycles", n_vcyc, 0);
    clr_counts();
    tick(0, 1, 4'd1, 1, 0, 0);
    chk("t4 fault cleared", fault, 0);
    wait_payout(20, 100, 0, 0);
    chk("t4 retry paid", paid, 1);
    chk("t4 retry nickels", n_nacc, 1);

    // 5: dime held while the hopper stalls and dime_empty toggles
    clr_counts();
    tick(0, 1, 4'd2, 0, 0, 0);
    tick(0, 0, 4'd0, 0, 0, 0);
    for (int i = 0; i < 10; i++) tick(0, 0, 4'd0, 0, i[0], 0);
    chk("t5 dime held cycles", n_dime_seen, 11);
    tick(0, 0, 4'd0, 1, 1, 0);
    chk("t5 paid on first ready", paid, 2);
    chk("t5 dimes", n_dacc, 1);
    wait_payout(20, 100, 0, 0);

    // 6: reset during an offer, then start pulses while busy
    clr_counts();
    tick(0, 1, 4'd5, 0, 0, 0);
    tick(0, 0, 4'd0, 0, 0, 0);
    tick(0, 1, 4'd1, 0, 0, 0);
    chk("t6 offering before rst", coin_valid, 1);
    tick(1, 0, 4'd0, 0, 0, 0);
    chk("t6 rst outputs", {coin, coin_valid, busy, done, fault, paid}, 0);
    tick(0, 1, 4'd5, 1, 0, 0);
    for (int i = 0; i < 6; i++) tick(0, 1, 4'd1, 1, 0, 0);
    wait_payout(100, 100, 0, 0);
    chk("t6 paid not re-latched", paid, 5);

    // Randomized run over all inputs
    for (int i = 0; i < 6000; i++) begin
      tick(($urandom_range(0, 299) == 0), ($urandom_range(0, 2) == 0),
           4'($urandom_range(0, 15)), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
